// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the result consumer.
// The slave side belongs to the arbiter; master is the requester/consumer side.
interface alu_arbiter_if;
   logic       req0_valid;
   logic [1:0] req0_op;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req0_ready;
   logic       req1_valid;
   logic [1:0] req1_op;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       req1_ready;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_data;
   logic       rsp_flag;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_flag
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_flag
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared decoder-style ALU: accept one
// operation, hold the ALU inputs SETTLE cycles, capture the selected output, hand it back.
module alu_arbiter #(
   parameter int unsigned SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus,
   output logic [1:0]   alu_s,
   output logic [3:0]   alu_a,
   output logic [3:0]   alu_b,
   input  logic [3:0]   alu_y0,
   input  logic [3:0]   alu_y1,
   input  logic [3:0]   alu_y2,
   input  logic [3:0]   alu_y3,
   input  logic         alu_cout,
   input  logic         alu_sign,
   output logic [7:0]   done_cnt
);

   localparam int unsigned CW = (SETTLE > 32'd1) ? $clog2(SETTLE) : 32'd1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    alu_s_q, alu_s_d;
   logic [3:0]    alu_a_q, alu_a_d;
   logic [3:0]    alu_b_q, alu_b_d;
   logic          id_q, id_d;
   logic [3:0]    data_q, data_d;
   logic          flag_q, flag_d;
   logic [7:0]    done_q, done_d;
   logic          grant_s;
   logic          accept_s;
   logic [4:0]    capture_s;

   // Decoder ALU drives one output group per select; flag is only meaningful for add/sub.
   function automatic logic [4:0] capture_mux(
      input logic [1:0] op,
      input logic [3:0] y0, input logic [3:0] y1,
      input logic [3:0] y2, input logic [3:0] y3,
      input logic       cout, input logic sign
   );
      logic [4:0] r;
      r = 5'd0;
      case (op)
         2'b00:   r = {cout, y0};
         2'b01:   r = {sign, y1};
         2'b10:   r = {1'b0, y2};
         2'b11:   r = {1'b0, y3};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   // Grant selection: a lone valid wins, a tie goes to the priority pointer.
   always_comb begin
      grant_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_s = ptr_q;
      end else if (bus.req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign accept_s   = !rst && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
   assign capture_s  = capture_mux(alu_s_q, alu_y0, alu_y1, alu_y2, alu_y3, alu_cout, alu_sign);

   assign bus.req0_ready = accept_s && !grant_s;
   assign bus.req1_ready = accept_s && grant_s;
   assign bus.rsp_valid  = !rst && (state_q == ST_RESP);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_flag   = flag_q;
   assign alu_s          = alu_s_q;
   assign alu_a          = alu_a_q;
   assign alu_b          = alu_b_q;
   assign done_cnt       = done_q;

   // Next-state logic for the IDLE -> EXEC -> RESP sequence and all payload registers.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      alu_s_d = alu_s_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      id_d    = id_q;
      data_d  = data_q;
      flag_d  = flag_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_EXEC;
               id_d    = grant_s;
               cnt_d   = CW'(SETTLE - 32'd1);
               if (grant_s) begin
                  alu_s_d = bus.req1_op;
                  alu_a_d = bus.req1_a;
                  alu_b_d = bus.req1_b;
               end else begin
                  alu_s_d = bus.req0_op;
                  alu_a_d = bus.req0_a;
                  alu_b_d = bus.req0_b;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_RESP;
               data_d  = capture_s[3:0];
               flag_d  = capture_s[4];
            end else begin
               cnt_d = cnt_q - CW'(1'b1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
               done_d  = done_q + 8'd1;
               ptr_d   = ~id_q;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and payload registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         alu_s_q <= 2'b00;
         alu_a_q <= 4'b0000;
         alu_b_q <= 4'b0000;
         id_q    <= 1'b0;
         data_q  <= 4'b0000;
         flag_q  <= 1'b0;
         done_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         alu_s_q <= alu_s_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         id_q    <= id_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles (>=1) ALU inputs are held stable before the result is captured.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  in  1  requester n has an operation pending.
REQ-005 req0_op / req1_op  in  2  ALU select: 00 add, 01 subtract, 10 compare, 11 logic op.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  4  operands.
REQ-007 req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready.
REQ-008 alu_s  out  2, alu_a  out  4, alu_b  out  4  drive the shared decoder ALU's s, a, b.
REQ-009 alu_y0, alu_y1, alu_y2, alu_y3  in  4  ALU outputs; alu_cout in 1; alu_sign in 1.
REQ-010 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts.
REQ-011 rsp_id  out  1  requester that issued the response; rsp_data  out  4; rsp_flag  out  1.
REQ-012 done_cnt  out  8  count of completed responses.

Function
REQ-013 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-014 IDLE: grant = requester with valid set; if both valid, the one indicated by priority pointer ptr.
REQ-015 reqN_ready = 1 only in IDLE and only for the granted requester; otherwise 0 (combinational from state, valids, ptr).
REQ-016 On acceptance edge: latch op, a, b into alu_s, alu_a, alu_b; latch id; load settle counter with SETTLE-1; go EXEC.
REQ-017 alu_s/alu_a/alu_b are registers; they hold their last value in every state except the acceptance edge.
REQ-018 EXEC lasts exactly SETTLE cycles; on its last edge capture result, go RESP.
REQ-019 Capture mux: op 00 -> data=alu_y0, flag=alu_cout; 01 -> alu_y1, alu_sign; 10 -> alu_y2, 0; 11 -> alu_y3, 0.
REQ-020 rsp_valid = 1 in RESP only; rsp_id/rsp_data/rsp_flag stable throughout RESP.
REQ-021 rsp_valid asserts SETTLE+1 cycles after the acceptance cycle.
REQ-022 RESP with rsp_ready=1: go IDLE next edge, increment done_cnt, set ptr to the requester other than rsp_id.
REQ-023 RESP with rsp_ready=0: remain in RESP indefinitely; no new request accepted.
REQ-024 done_cnt wraps 255 -> 0.
REQ-025 Back-to-back: earliest next acceptance is the IDLE cycle following the response handshake (one accept per SETTLE+2 cycles minimum).
REQ-026 Requester dropping valid before acceptance: no grant, no state change.
REQ-027 Only the accepted requester's inputs are sampled; operand changes after acceptance do not affect the result.

Reset
REQ-028 rst at a clock edge forces IDLE, ptr=0 (req0 preferred), settle counter 0, alu_s=00, alu_a=0000, alu_b=0000, rsp_id=0, rsp_data=0000, rsp_flag=0, done_cnt=0.
REQ-029 During reset-asserted cycles req0_ready, req1_ready, rsp_valid are 0.
REQ-030 rst mid-EXEC or mid-RESP abandons the operation; no response issued, done_cnt not incremented.

Verification
REQ-031 SETTLE=1, decoder connected, req0 op=00 a=0111 b=1110 -> accept cycle 0, rsp_valid cycle 2, rsp_id=0, rsp_data=0101, rsp_flag=1.
REQ-032 req1 op=10 a=0111 b=1110 -> rsp_id=1, rsp_data=0010 ({0,ga,gb,e}), rsp_flag=0.
REQ-033 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; done_cnt=4 after four responses.
REQ-034 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and payload stable, both ready outputs 0, done_cnt unchanged.
REQ-035 rst asserted one cycle in EXEC -> next cycle IDLE, all outputs at reset values, no rsp_valid.
REQ-036 SETTLE=3, 256 completed ops -> done_cnt=0, rsp_valid each time 4 cycles after acceptance.
